// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the instruction register and the immediate generator.
// The master side supplies instructions and consumes immediates. The slave side is the generator.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [2:0]      mode;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            illegal;

  modport master (
    output in_valid, inst, mode, out_ready,
    input  in_ready, out_valid, imm, fmt, illegal
  );

  modport slave (
    input  in_valid, inst, mode, out_ready,
    output in_ready, out_valid, imm, fmt, illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator. It supports explicit or opcode-inferred (AUTO) formats.
// Results pass through a 2-entry skid FIFO so that decode can stall without dropping instructions.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  imm_gen_pipe_if.slave  bus
);

  localparam logic [2:0] FMT_ZERO  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_SHAMT = 3'd2;
  localparam logic [2:0] FMT_U     = 3'd3;
  localparam logic [2:0] FMT_J     = 3'd4;
  localparam logic [2:0] FMT_B     = 3'd5;
  localparam logic [2:0] FMT_S     = 3'd6;
  localparam logic [2:0] MODE_AUTO = 3'd7;

  // One buffer entry is {imm, fmt, illegal}.
  localparam int EW = XLEN + 4;

  function automatic logic [XLEN-1:0] build_imm(input logic [31:0] inst, input logic [2:0] fmt);
    logic [XLEN-1:0] v;
    case (fmt)
      FMT_I:     v = XLEN'($signed(inst[31:20]));
      FMT_SHAMT: v = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
      FMT_U:     v = XLEN'($signed({inst[31:12], 12'h000}));
      FMT_J:     v = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      FMT_B:     v = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      FMT_S:     v = XLEN'($signed({inst[31:25], inst[11:7]}));
      default:   v = '0;
    endcase
    return v;
  endfunction

  logic [1:0]    r_count;
  logic [EW-1:0] r_e0;
  logic [EW-1:0] r_e1;

  logic [2:0]      w_fmt;
  logic            w_ill;
  logic [XLEN-1:0] w_imm;
  logic [EW-1:0]   w_new;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_push;
  logic            w_pop;

  // Resolve the format. In AUTO mode it comes from the opcode. Otherwise the mode passes through.
  always_comb begin
    w_fmt = FMT_ZERO;
    w_ill = 1'b0;
    if (bus.mode == MODE_AUTO) begin
      case (bus.inst[6:0])
        7'b0010011: begin
          if ((bus.inst[14:12] == 3'b001) || (bus.inst[14:12] == 3'b101)) begin
            w_fmt = FMT_SHAMT;
          end else begin
            w_fmt = FMT_I;
          end
        end
        7'b0000011, 7'b1100111, 7'b1110011: w_fmt = FMT_I;
        7'b0100011:                         w_fmt = FMT_S;
        7'b1100011:                         w_fmt = FMT_B;
        7'b0110111, 7'b0010111:             w_fmt = FMT_U;
        7'b1101111:                         w_fmt = FMT_J;
        default: begin
          w_fmt = FMT_ZERO;
          w_ill = 1'b1;
        end
      endcase
    end else begin
      w_fmt = bus.mode;
      w_ill = 1'b0;
    end
  end

  assign w_imm       = build_imm(bus.inst, w_fmt);
  assign w_new       = {w_imm, w_fmt, w_ill};
  assign w_in_ready  = (r_count != 2'd2);
  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  // FIFO storage. Vacated slots are cleared so that the head reads as zero when the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_e0    <= '0;
      r_e1    <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_e0 <= w_new;
          end else begin
            r_e1 <= w_new;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_e0    <= r_e1;
          r_e1    <= '0;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Only reachable at count 1: the new entry replaces the departing head.
          r_e0 <= w_new;
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.imm       = r_e0[EW-1:4];
  assign bus.fmt       = r_e0[3:1];
  assign bus.illegal   = r_e0[0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe. It instantiates one XLEN=32 and one XLEN=64 generator on a shared clock and reset.
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) a ();
  imm_gen_pipe_if #(.XLEN(64)) b ();

  imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(a.slave));
  imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(b.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] inst, input logic [2:0] mode);
    a.in_valid = v;
    a.inst     = inst;
    a.mode     = mode;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] inst, input logic [2:0] mode);
    b.in_valid = v;
    b.inst     = inst;
    b.mode     = mode;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
    chk({tag, ".valid"}, 64'(a.out_valid), 64'd1);
    chk({tag, ".imm"},   64'(a.imm),       64'(imm));
    chk({tag, ".fmt"},   64'(a.fmt),       64'(fmt));
    chk({tag, ".ill"},   64'(a.illegal),   64'(ill));
  endtask

  initial begin
    rst = 1'b1;
    drive_a(1'b1, 32'hFFF00093, 3'd7);
    a.out_ready = 1'b1;
    drive_b(1'b0, 32'h0, 3'd0);
    b.out_ready = 1'b0;

    // Two reset cycles with in_valid high.
    step();
    chk("rst1.valid", 64'(a.out_valid), 64'd0);
    chk("rst1.imm",   64'(a.imm),       64'd0);
    chk("rst1.ready", 64'(a.in_ready),  64'd1);
    drive_a(1'b0, 32'hFFF00093, 3'd7);
    step();
    chk("rst2.valid", 64'(a.out_valid), 64'd0);
    chk("rst2.ready", 64'(a.in_ready),  64'd1);
    chk("rst2.fmt",   64'(a.fmt),       64'd0);
    rst = 1'b0;
    step();
    chk("post_rst.valid", 64'(a.out_valid), 64'd0);
    chk("post_rst.b_valid", 64'(b.out_valid), 64'd0);

    // AUTO decode, back-to-back.
    drive_a(1'b1, 32'hFFF00093, 3'd7); step(); chk_a("auto_i",     32'hFFFFFFFF, 3'd1, 1'b0);
    drive_a(1'b1, 32'h00509093, 3'd7); step(); chk_a("auto_shamt", 32'h00000005, 3'd2, 1'b0);
    drive_a(1'b1, 32'h123450B7, 3'd7); step(); chk_a("auto_u",     32'h12345000, 3'd3, 1'b0);
    drive_a(1'b1, 32'h0040006F, 3'd7); step(); chk_a("auto_j",     32'h00000004, 3'd4, 1'b0);

    // Explicit modes.
    drive_a(1'b1, 32'hFE000EE3, 3'd5); step(); chk_a("mode_b",    32'hFFFFFFFC, 3'd5, 1'b0);
    drive_a(1'b1, 32'hFE112E23, 3'd6); step(); chk_a("mode_s",    32'hFFFFFFFC, 3'd6, 1'b0);
    drive_a(1'b1, 32'hFFFFFFFF, 3'd0); step(); chk_a("mode_zero", 32'h00000000, 3'd0, 1'b0);

    // Illegal opcode in AUTO, and the same word under an explicit mode.
    drive_a(1'b1, 32'h00000000, 3'd7); step(); chk_a("illegal",   32'h00000000, 3'd0, 1'b1);
    drive_a(1'b1, 32'h00000000, 3'd1); step(); chk_a("legal_i",   32'h00000000, 3'd1, 1'b0);

    drive_a(1'b0, 32'h0, 3'd0);
    step();
    chk("drain.valid", 64'(a.out_valid), 64'd0);
    chk("drain.imm",   64'(a.imm),       64'd0);

    // Backpressure: A=1, B=2, C=3 via explicit I format.
    a.out_ready = 1'b0;
    drive_a(1'b1, 32'h00100093, 3'd1); step();
    chk_a("bp_a", 32'd1, 3'd1, 1'b0);
    chk("bp_a.ready", 64'(a.in_ready), 64'd1);
    drive_a(1'b1, 32'h00200093, 3'd1); step();
    chk("bp_b.ready", 64'(a.in_ready), 64'd0);
    chk_a("bp_b_head", 32'd1, 3'd1, 1'b0);
    drive_a(1'b1, 32'h00300093, 3'd1); step();
    chk("bp_c.ready", 64'(a.in_ready), 64'd0);
    chk_a("bp_c_head", 32'd1, 3'd1, 1'b0);
    a.out_ready = 1'b1;
    step();
    chk_a("bp_out_b", 32'd2, 3'd1, 1'b0);
    chk("bp_out_b.ready", 64'(a.in_ready), 64'd1);
    step();
    chk_a("bp_out_c", 32'd3, 3'd1, 1'b0);
    drive_a(1'b0, 32'h0, 3'd0);
    step();
    chk("bp_empty.valid", 64'(a.out_valid), 64'd0);

    // XLEN=64.
    drive_b(1'b1, 32'h800000B7, 3'd3); step();
    chk("x64_u.valid", 64'(b.out_valid), 64'd1);
    chk("x64_u.imm",   b.imm,            64'hFFFFFFFF80000000);
    chk("x64_u.fmt",   64'(b.fmt),       64'd3);
    drive_b(1'b1, 32'h03F09093, 3'd2); step();
    chk("x64_full.ready", 64'(b.in_ready), 64'd0);
    drive_b(1'b0, 32'h0, 3'd0);
    b.out_ready = 1'b1;
    step();
    chk("x64_shamt.imm", b.imm,      64'd63);
    chk("x64_shamt.fmt", 64'(b.fmt), 64'd2);
    b.out_ready = 1'b0;
    drive_b(1'b1, 32'h00100093, 3'd1); step();
    drive_b(1'b1, 32'h00200093, 3'd1); step();
    chk("x64_refill.ready", 64'(b.in_ready), 64'd0);
    chk("x64_refill.imm",   b.imm,           64'd63);
    drive_b(1'b0, 32'h0, 3'd0);
    rst = 1'b1;
    step();
    chk("x64_rst.valid", 64'(b.out_valid), 64'd0);
    chk("x64_rst.imm",   b.imm,            64'd0);
    chk("x64_rst.ready", 64'(b.in_ready),  64'd1);
    rst = 1'b0;
    step();
    chk("x64_rst_after.valid", 64'(b.out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, handshaked immediate generator for the decode stage. Accepts a 32-bit instruction and a format mode, and produces an XLEN-wide sign/zero-extended immediate through a 2-entry skid buffer. It adds an AUTO mode that infers the format from the opcode, and flags opcodes it cannot decode. It sits between the fetch/IR register and the execute operand mux, and lets decode stall without losing instructions.

## Interface
Parameters:
- XLEN, 32, immediate width; legal values 32 or 64.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  inst/mode are valid this cycle.
- in_ready  out  1  buffer can accept an entry (not full).
- inst  in  32  instruction word.
- mode  in  3  format select: 0 zero, 1 I, 2 shamt, 3 U, 4 J, 5 B, 6 S, 7 AUTO.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes the head entry this cycle.
- imm  out  XLEN  immediate of the head entry.
- fmt  out  3  resolved format (1..6, or 0), never 7.
- illegal  out  1  AUTO mode found no matching opcode.

## Operation
- Format rules (s = inst[31] replicated up to XLEN):
  - zero: 0.
  - I: {s, inst[31:20]}.
  - shamt: zero-extended inst[24:20] when XLEN=32; inst[25:20] when XLEN=64.
  - U: {s above bit 31, inst[31:12], 12'b0}.
  - J: {s, inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - B: {s, inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - S: {s, inst[31:25], inst[11:7]}.
- AUTO decode on opcode inst[6:0]:
  - 0010011 with funct3 inst[14:12] = 001 or 101 → shamt.
  - 0010011 with any other funct3, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111 or 0010111 → U.
  - 1101111 → J.
  - Any other opcode → zero with illegal = 1.
- illegal is always 0 for explicit modes 0..6.
- The immediate, fmt and illegal are computed combinationally at input. They are stored as one entry of {imm, fmt, illegal}.
- Buffer: 2 entries, FIFO order, count register in the range 0..2.
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count != 2). It depends only on registered state, so there is no combinational path from out_ready.
  - out_valid = (count != 0).
  - With count == 0, imm, fmt and illegal are driven to 0.
- Simultaneous push and pop:
  - count 1: count stays 1; the head is replaced by the new entry.
  - count 0: no pop is possible; count becomes 1.
  - count 2: no push is possible; count becomes 1.
- inst and mode are sampled only on a push. Changes while in_ready = 0 have no effect.

## Timing
- Reset (rst high at a clock edge): count = 0, out_valid = 0, in_ready = 1, imm = 0, fmt = 0, illegal = 0. Both entries are invalidated.
- Reset mid-operation discards buffered entries. The first cycle after reset release already shows in_ready = 1.
- Latency: an entry pushed at edge N is on the outputs with out_valid = 1 after edge N (cycle N+1), provided it is at the head.
- Throughput: 1 entry per cycle when out_ready is held high.
- Backpressure: with out_ready low, two pushes fill the buffer, and in_ready drops in the cycle after the second push.
- One cycle with out_ready high pops one entry, and in_ready returns to 1 the next cycle.
- Outputs must hold stable while out_valid && !out_ready.

## Test plan
- Reset: assert rst for 2 cycles with in_valid = 1 → out_valid = 0, imm = 0, in_ready = 1. Nothing is buffered afterwards.
- AUTO decode, XLEN=32, out_ready = 1, one instruction per cycle:
  - 0xFFF00093 → imm 0xFFFFFFFF, fmt 1.
  - 0x00509093 → imm 0x00000005, fmt 2.
  - 0x123450B7 → imm 0x12345000, fmt 3.
  - 0x0040006F → imm 0x00000004, fmt 4.
  - Each result appears one cycle after its push, back-to-back.
- Explicit modes, XLEN=32:
  - mode 5, inst 0xFE000EE3 → imm 0xFFFFFFFC.
  - mode 6, inst 0xFE112E23 → imm 0xFFFFFFFC.
  - mode 0 → imm 0.
- Illegal: mode 7, inst 0x00000000 → imm 0, fmt 0, illegal 1. The same inst with mode 1 → illegal 0.
- Backpressure: hold out_ready = 0 and push 3 entries (A, B, C) → C is stalled, in_ready = 0, and out_valid = 1 shows A steady. Then raise out_ready → A, B, C emerge in order with no loss or duplication.
- XLEN=64:
  - mode 3, inst 0x800000B7 → imm 0xFFFFFFFF80000000.
  - mode 2, inst 0x03F09093 → imm 63.
  - Assert rst with 2 entries buffered → out_valid = 0 next cycle.
